// File: rtl/vadd_pkg.sv
// Shared definitions for the vadd CAE memory path: state encoding,
// request field widths and request FIFO watermark constants.
package vadd_pkg;

  localparam int unsigned VADR_W = 48;
  localparam int unsigned SIZE_W = 2;
  localparam int unsigned WRD_W  = 64;

  localparam int unsigned DEPTH  = 32;
  localparam int unsigned WMTHLD = 26;
  localparam int unsigned STALL_MARGIN = DEPTH - WMTHLD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: grants the first eligible requester at
// or after the pointer, scanning upward modulo NREQ.
module rr_pick #(
  parameter  int unsigned NREQ = 3,
  localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] elig_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_oh_o,
  output logic [PW-1:0]   gnt_idx_o,
  output logic            gnt_vld_o
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = PW'((32'(ptr_i) + k) % NREQ);
      if (!found && elig_i[idx]) begin
        found         = 1'b1;
        gnt_oh_o[idx] = 1'b1;
        gnt_idx_o     = idx;
      end
    end
    gnt_vld_o = found;
  end

endmodule

// File: rtl/vadd_req_arb.sv
// Request-side arbiter for the vadd memory path: round-robin share of the
// request FIFO push port, stall throttling, per-stream completion tracking.
module vadd_req_arb
  import vadd_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned CNTW = 32
) (
  input  logic                     clk167,
  input  logic                     reset167,
  input  logic                     start,
  input  logic [NREQ-1:0]          en_mask,
  input  logic [NREQ-1:0]          rq_vld,
  output logic [NREQ-1:0]          rq_rdy,
  input  logic [NREQ-1:0]          rq_last,
  input  logic [NREQ-1:0]          rq_ld_st,
  input  logic [NREQ*VADR_W-1:0]   rq_vadr,
  input  logic [NREQ*SIZE_W-1:0]   rq_size,
  input  logic [NREQ*WRD_W-1:0]    rq_wrd_rdctl,
  input  logic                     req_stall,
  input  logic                     req_idle,
  output logic                     req_push,
  output logic                     req_last,
  output logic                     req_ld_st,
  output logic [VADR_W-1:0]        req_vadr,
  output logic [SIZE_W-1:0]        req_size,
  output logic [WRD_W-1:0]         req_wrd_rdctl,
  output logic                     busy,
  output logic                     done,
  output logic [NREQ*CNTW-1:0]     acc_cnt
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // One push may already be registered when stall rises; the FIFO needs room for it.
  if (STALL_MARGIN < 2) begin : g_margin_check
    $error("request FIFO watermark leaves no room for the in-flight push");
  end

  arb_state_t                    state_q, state_d;
  logic [NREQ-1:0]               r_en_q, r_en_d;
  logic [NREQ-1:0]               done_vec_q, done_vec_d;
  logic [PW-1:0]                 ptr_q, ptr_d;
  logic [NREQ-1:0][CNTW-1:0]     cnt_q, cnt_d;
  logic                          idle_seen_q, idle_seen_d;
  logic                          done_q, done_d;
  logic                          push_q, push_d;
  logic                          last_q, last_d;
  logic                          ld_st_q, ld_st_d;
  logic [VADR_W-1:0]             vadr_q, vadr_d;
  logic [SIZE_W-1:0]             size_q, size_d;
  logic [WRD_W-1:0]              wrd_q, wrd_d;

  logic [NREQ-1:0][VADR_W-1:0]   vadr_a;
  logic [NREQ-1:0][SIZE_W-1:0]   size_a;
  logic [NREQ-1:0][WRD_W-1:0]    wrd_a;

  logic [NREQ-1:0]               elig;
  logic [NREQ-1:0]               gnt_oh;
  logic [PW-1:0]                 gnt_idx;
  logic                          gnt_vld;
  logic                          accept;

  assign vadr_a = rq_vadr;
  assign size_a = rq_size;
  assign wrd_a  = rq_wrd_rdctl;

  assign elig = (state_q == RUN) ? (rq_vld & r_en_q & ~done_vec_q) : '0;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .elig_i    (elig),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  assign accept = gnt_vld & ~req_stall;
  assign rq_rdy = req_stall ? '0 : gnt_oh;

  always_comb begin
    state_d     = state_q;
    r_en_d      = r_en_q;
    done_vec_d  = done_vec_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    idle_seen_d = idle_seen_q;
    done_d      = 1'b0;
    push_d      = 1'b0;
    last_d      = last_q;
    ld_st_d     = ld_st_q;
    vadr_d      = vadr_q;
    size_d      = size_q;
    wrd_d       = wrd_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          r_en_d      = en_mask;
          done_vec_d  = '0;
          cnt_d       = '0;
          ptr_d       = '0;
          idle_seen_d = 1'b0;
          state_d     = (en_mask == '0) ? DRAIN : RUN;
        end
      end

      RUN: begin
        if (accept) begin
          push_d         = 1'b1;
          last_d         = rq_last[gnt_idx];
          ld_st_d        = rq_ld_st[gnt_idx];
          vadr_d         = vadr_a[gnt_idx];
          size_d         = size_a[gnt_idx];
          wrd_d          = wrd_a[gnt_idx];
          cnt_d[gnt_idx] = cnt_q[gnt_idx] + 1'b1;
          ptr_d          = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          if (rq_last[gnt_idx]) begin
            done_vec_d[gnt_idx] = 1'b1;
          end
        end
        // Exit tests the post-accept vector so the cycle after the final accept is DRAIN.
        if (done_vec_d == r_en_q) begin
          state_d     = DRAIN;
          idle_seen_d = 1'b0;
        end
      end

      DRAIN: begin
        if (!push_q && req_idle) begin
          if (idle_seen_q) begin
            done_d      = 1'b1;
            idle_seen_d = 1'b0;
            state_d     = IDLE;
          end else begin
            idle_seen_d = 1'b1;
          end
        end else begin
          idle_seen_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk167) begin
    if (reset167) begin
      state_q     <= IDLE;
      r_en_q      <= '0;
      done_vec_q  <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      idle_seen_q <= 1'b0;
      done_q      <= 1'b0;
      push_q      <= 1'b0;
      last_q      <= 1'b0;
      ld_st_q     <= 1'b0;
      vadr_q      <= '0;
      size_q      <= '0;
      wrd_q       <= '0;
    end else begin
      state_q     <= state_d;
      r_en_q      <= r_en_d;
      done_vec_q  <= done_vec_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      idle_seen_q <= idle_seen_d;
      done_q      <= done_d;
      push_q      <= push_d;
      last_q      <= last_d;
      ld_st_q     <= ld_st_d;
      vadr_q      <= vadr_d;
      size_q      <= size_d;
      wrd_q       <= wrd_d;
    end
  end

  assign req_push      = push_q;
  assign req_last      = last_q;
  assign req_ld_st     = ld_st_q;
  assign req_vadr      = vadr_q;
  assign req_size      = size_q;
  assign req_wrd_rdctl = wrd_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign acc_cnt       = cnt_q;

endmodule

// File: tb/tb_vadd_req_arb.sv
// Randomised scoreboard bench for vadd_req_arb against a cycle-level
// reference model of the round-robin / drain rules.
module tb_vadd_req_arb;

  localparam int N  = 3;
  localparam int CW = 32;

  logic              clk167 = 1'b0;
  logic              reset167;
  logic              start;
  logic [N-1:0]      en_mask, rq_vld, rq_rdy, rq_last, rq_ld_st;
  logic [N*48-1:0]   rq_vadr;
  logic [N*2-1:0]    rq_size;
  logic [N*64-1:0]   rq_wrd_rdctl;
  logic              req_stall, req_idle;
  logic              req_push, req_last, req_ld_st;
  logic [47:0]       req_vadr;
  logic [1:0]        req_size;
  logic [63:0]       req_wrd_rdctl;
  logic              busy, done;
  logic [N*CW-1:0]   acc_cnt;

  always #5 clk167 = ~clk167;

  vadd_req_arb #(.NREQ(N), .CNTW(CW)) dut (
    .clk167(clk167), .reset167(reset167), .start(start), .en_mask(en_mask),
    .rq_vld(rq_vld), .rq_rdy(rq_rdy), .rq_last(rq_last), .rq_ld_st(rq_ld_st),
    .rq_vadr(rq_vadr), .rq_size(rq_size), .rq_wrd_rdctl(rq_wrd_rdctl),
    .req_stall(req_stall), .req_idle(req_idle), .req_push(req_push),
    .req_last(req_last), .req_ld_st(req_ld_st), .req_vadr(req_vadr),
    .req_size(req_size), .req_wrd_rdctl(req_wrd_rdctl), .busy(busy),
    .done(done), .acc_cnt(acc_cnt)
  );

  typedef struct packed {
    logic [47:0] vadr;
    logic [1:0]  size;
    logic [63:0] wrd;
    logic        ld_st;
    logic        last;
  } req_t;

  req_t sq[N][$];
  req_t sb[$];
  int   glog[$];

  int errors = 0;
  int checks = 0;

  // reference model state
  int           m_st;
  logic [N-1:0] m_en, m_dv;
  int           m_ptr, m_consec;
  int           m_cnt[N];
  logic         exp_push, exp_done;

  // stimulus knobs
  bit           fifo_ideal;
  int           fifo_cnt;
  int           gap_pct;
  int           stall_mode, stall_from, stall_len;
  logic [N-1:0] stray;
  int           cyc, run_cyc;
  int           last_push_cyc, done_cyc;
  int           late_push, rdy_in_stall;
  logic         stall_prev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk167) begin
    req_t e;
    if (req_push === 1'b1) begin
      last_push_cyc = cyc;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL push_unexpected: got vadr %0h expected no push", req_vadr);
      end else begin
        e = sb.pop_front();
        chk("push_vadr", req_vadr, e.vadr);
        chk("push_size", req_size, e.size);
        chk("push_wrd", req_wrd_rdctl, e.wrd);
        chk("push_ldst", req_ld_st, e.ld_st);
        chk("push_last", req_last, e.last);
      end
    end
  end

  task automatic drive_req(input int i, input req_t r);
    rq_vld[i]             = 1'b1;
    rq_vadr[i*48 +: 48]   = r.vadr;
    rq_size[i*2 +: 2]     = r.size;
    rq_wrd_rdctl[i*64 +: 64] = r.wrd;
    rq_ld_st[i]           = r.ld_st;
    rq_last[i]            = r.last;
  endtask

  task automatic cycle();
    logic [N-1:0] elig, xrdy;
    int           g, pi;
    logic         acc, nxt_push, nxt_done;
    req_t         r;
    @(negedge clk167);
    elig = '0;
    xrdy = '0;
    g    = -1;
    if (m_st == 1) begin
      elig = rq_vld & m_en & ~m_dv;
      for (int k = 0; k < N; k++) begin
        pi = (m_ptr + k) % N;
        if (g < 0 && elig[pi]) g = pi;
      end
    end
    acc = (g >= 0) && !req_stall;
    if (acc) xrdy[g] = 1'b1;

    chk("rq_rdy", rq_rdy, xrdy);
    chk("req_push", req_push, exp_push);
    chk("done", done, exp_done);
    chk("busy", busy, m_st != 0);

    if (done) done_cyc = cyc;
    if (req_stall && stall_prev && req_push) late_push++;
    if (req_stall && rq_rdy != '0) rdy_in_stall++;
    stall_prev = req_stall;
    for (int i = 0; i < N; i++) if (rq_rdy[i]) glog.push_back(i);

    nxt_push = 1'b0;
    nxt_done = 1'b0;
    case (m_st)
      0: if (start) begin
        m_en = en_mask; m_dv = '0; m_ptr = 0; m_consec = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_st = (en_mask == '0) ? 2 : 1;
      end
      1: begin
        if (acc) begin
          r = sq[g].pop_front();
          sb.push_back(r);
          m_cnt[g]++;
          m_ptr = (g + 1) % N;
          if (r.last) m_dv[g] = 1'b1;
          nxt_push = 1'b1;
        end
        if (m_dv == m_en) begin m_st = 2; m_consec = 0; end
      end
      default: begin
        if (!exp_push && req_idle) begin
          m_consec++;
          if (m_consec == 2) begin nxt_done = 1'b1; m_st = 0; m_consec = 0; end
        end else m_consec = 0;
      end
    endcase

    @(posedge clk167);
    #1;
    cyc++;
    run_cyc++;
    if (fifo_cnt > 0 && $urandom_range(0, 2) == 0) fifo_cnt--;
    if (exp_push) fifo_cnt++;
    if (reset167) begin
      m_st = 0; m_en = '0; m_dv = '0; m_ptr = 0; m_consec = 0;
      for (int i = 0; i < N; i++) begin m_cnt[i] = 0; sq[i].delete(); end
      sb.delete();
      nxt_push = 1'b0;
      nxt_done = 1'b0;
      rq_vld = '0;
      acc = 1'b0;
    end
    exp_push = nxt_push;
    exp_done = nxt_done;
    req_idle = fifo_ideal ? 1'b1 : (fifo_cnt == 0);
    case (stall_mode)
      1:       req_stall = ($urandom_range(0, 9) == 0);
      2:       req_stall = (run_cyc >= stall_from) && (run_cyc < stall_from + stall_len);
      default: req_stall = 1'b0;
    endcase
    for (int i = 0; i < N; i++) begin
      if (acc && g == i) rq_vld[i] = 1'b0;
      if (!rq_vld[i]) begin
        if (sq[i].size() > 0) begin
          if ($urandom_range(0, 99) >= gap_pct) drive_req(i, sq[i][0]);
        end else if (stray[i]) begin
          r.vadr = {16'hdead, 32'($urandom)};
          r.size = 2'($urandom);
          r.wrd  = {$urandom, $urandom};
          r.ld_st = 1'b0;
          r.last  = 1'b1;
          drive_req(i, r);
        end
      end
    end
  endtask

  task automatic do_run(input logic [N-1:0] mask, input int n0, input int n1, input int n2,
                        input int mid_k, input int rst_k);
    int   n[N];
    int   k;
    req_t r;
    n[0] = n0; n[1] = n1; n[2] = n2;
    for (int i = 0; i < N; i++) begin
      sq[i].delete();
      for (int j = 0; j < n[i]; j++) begin
        r.vadr  = {16'(i), 32'($urandom)};
        r.size  = 2'($urandom);
        r.wrd   = {$urandom, $urandom};
        r.ld_st = (i == 2);
        r.last  = (j == n[i] - 1);
        sq[i].push_back(r);
      end
    end
    rq_vld = '0;
    glog.delete();
    late_push = 0; rdy_in_stall = 0;
    last_push_cyc = -100; done_cyc = -1;
    en_mask = mask;
    start = 1'b1;
    run_cyc = 0;
    cycle();
    start = 1'b0;
    k = 1;
    while (!exp_done && k < 400) begin
      if (k == mid_k) begin start = 1'b1; en_mask = ~mask; end
      if (k == rst_k) begin
        reset167 = 1'b1;
        cycle();
        reset167 = 1'b0;
        chk("rst_push", req_push, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", |acc_cnt, 0);
        repeat (8) cycle();
        return;
      end
      cycle();
      start = 1'b0;
      k++;
    end
    if (!exp_done) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: got no done after %0d cycles expected done", k);
    end else begin
      cycle();
    end
    chk("sb_empty", sb.size(), 0);
    for (int i = 0; i < N; i++) chk("acc_cnt_model", acc_cnt[i*CW +: CW], m_cnt[i]);
  endtask

  initial begin
    reset167 = 1'b1; start = 1'b0; en_mask = '0; rq_vld = '0; rq_last = '0; rq_ld_st = '0;
    rq_vadr = '0; rq_size = '0; rq_wrd_rdctl = '0; req_stall = 1'b0; req_idle = 1'b1;
    fifo_ideal = 1'b1; fifo_cnt = 0; gap_pct = 0; stall_mode = 0; stall_from = 0; stall_len = 0;
    stray = '0; cyc = 0; run_cyc = 0; stall_prev = 1'b0;
    m_st = 0; m_en = '0; m_dv = '0; m_ptr = 0; m_consec = 0; exp_push = 1'b0; exp_done = 1'b0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    repeat (2) @(posedge clk167);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_push", req_push, 0);
    chk("reset_vadr", req_vadr, 0);
    chk("reset_cnt", |acc_cnt, 0);
    reset167 = 1'b0;
    repeat (2) cycle();

    // single stream, ideal FIFO
    do_run(3'b001, 4, 0, 0, -1, -1);
    chk("single_cnt0", acc_cnt[0 +: CW], 4);
    chk("single_done_lat", done_cyc - last_push_cyc, 3);

    // fairness with all streams continuously valid
    fifo_ideal = 1'b0;
    do_run(3'b111, 5, 5, 5, -1, -1);
    chk("fair_len", glog.size(), 15);
    for (int k = 0; k < 15 && k < glog.size(); k++) chk("fair_order", glog[k], k % 3);

    // stall window mid-burst
    stall_mode = 2; stall_from = 5; stall_len = 5;
    do_run(3'b111, 6, 6, 6, -1, -1);
    chk("stall_late_push", late_push, 0);
    chk("stall_rdy", rdy_in_stall, 0);
    stall_mode = 0;

    // early finisher keeps rq_vld high after its last
    gap_pct = 20; stall_mode = 1; stray = 3'b010;
    do_run(3'b111, 6, 1, 6, -1, -1);
    chk("early_cnt0", acc_cnt[0*CW +: CW], 6);
    chk("early_cnt1", acc_cnt[1*CW +: CW], 1);
    chk("early_cnt2", acc_cnt[2*CW +: CW], 6);
    stray = '0; stall_mode = 0; gap_pct = 0;
    repeat (2) cycle();

    // empty run, then start ignored mid-run with a disabled stream chattering
    do_run(3'b000, 0, 0, 0, -1, -1);
    chk("empty_cnt", |acc_cnt, 0);
    stray = 3'b010; gap_pct = 30;
    do_run(3'b101, 3, 0, 3, 3, -1);
    chk("midstart_cnt0", acc_cnt[0*CW +: CW], 3);
    chk("midstart_cnt1", acc_cnt[1*CW +: CW], 0);
    chk("midstart_cnt2", acc_cnt[2*CW +: CW], 3);
    stray = '0; gap_pct = 0;
    repeat (2) cycle();

    // reset during an accept cycle
    do_run(3'b111, 4, 4, 4, -1, 4);
    repeat (2) cycle();

    // normal run after the abort
    fifo_ideal = 1'b1; gap_pct = 10; stall_mode = 1;
    do_run(3'b110, 0, 3, 5, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
